// File: rtl/fifo_gen.sv
// Synchronous FIFO with registered status flags, overflow/underflow pulses and
// a build-time choice between registered-read and first-word-fall-through output.
module fifo_gen #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    if (ADDR_W < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
        $error("fifo_gen: illegal parameter set (need ADDR_W>=2, 0<=AE_LEVEL<AF_LEVEL<=DEPTH)");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_ok, wr_ok, mem_we;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        data_out_d  = data_out_q;
        // A full FIFO still takes a write when the same edge frees a slot.
        rd_ok  = rd && !empty_q;
        wr_ok  = wr && (!full_q || rd_ok);
        mem_we = wr_ok && !clr;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_ok && !rd_ok) count_d = count_q + CNT_ONE;
            if (rd_ok && !wr_ok) count_d = count_q - CNT_ONE;
            overflow_d  = wr && !wr_ok;
            underflow_d = rd && !rd_ok;
        end

        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_C);
        almost_empty_d = (count_d <= AE_C);

        if (!clr) begin
            if (FWFT != 0) begin
                // The next head may be the word being written this very edge.
                if (count_d != '0) begin
                    if (wr_ok && (wr_ptr_q == rd_ptr_d)) data_out_d = data_in;
                    else                                 data_out_d = mem_q[rd_ptr_d];
                end
            end else if (rd_ok) begin
                data_out_d = mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            data_out_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            data_out_q     <= data_out_d;
        end
    end

    // Storage is never reset; only the control state above is.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out     = data_out_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: doc/fifo_gen.md
FIFO_GEN -- requirements
Module: fifo_gen

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 4, giving the storage depth as DEPTH = 2^ADDR_W words (16 by default).
REQ-003 The module SHALL have parameter AF_LEVEL, default 12, the almost-full threshold in words.
REQ-004 The module SHALL have parameter AE_LEVEL, default 4, the almost-empty threshold in words.
REQ-005 The module SHALL have parameter FWFT, default 0, selecting the read mode: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  the single clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush, active-high.
- wr  in  1  write request.
- rd  in  1  read request.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data.
- full  out  1  high when count = DEPTH.
- empty  out  1  high when count = 0.
- almost_full  out  1  high when count >= AF_LEVEL.
- almost_empty  out  1  high when count <= AE_LEVEL.
- count  out  ADDR_W+1  number of stored words.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.
REQ-007 Parameter legality SHALL be: ADDR_W >= 2 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH; the module SHALL stop elaboration with an error when this does not hold.

Function
REQ-008 Write and read pointers SHALL each be ADDR_W bits wide and wrap modulo DEPTH; count SHALL be the separately registered occupancy, range 0..DEPTH.
REQ-009 A write SHALL be accepted at a rising edge when wr=1 and either full=0, or full=1 with a read accepted at the same edge.
REQ-010 A read SHALL be accepted at a rising edge when rd=1 and empty=0.
REQ-011 When the FIFO is empty and rd=1, wr=1 at the same edge:
- the write is accepted;
- the read is rejected;
- count becomes 1.
REQ-012 When the FIFO is full and rd=1, wr=1 at the same edge, both are accepted and count stays DEPTH.
REQ-013 Count update per edge SHALL be: +1 for a write-only accept, -1 for a read-only accept, unchanged otherwise.
REQ-014 full, empty, almost_full and almost_empty SHALL be registered and valid in the same cycle as the count they describe.
REQ-015 overflow SHALL be high for exactly the one cycle after an edge at which wr=1 was rejected; underflow SHALL do the same for rejected reads.
REQ-016 In registered-read mode (FWFT=0):
- data_out SHALL load the head word on the edge that accepts a read, giving 1-cycle latency;
- data_out SHALL hold its value otherwise, including on a rejected read.
REQ-017 In first-word-fall-through mode (FWFT=1):
- whenever empty=0, data_out SHALL present the head word;
- a written word SHALL appear on data_out in the cycle after its write into an empty FIFO;
- an accepted read SHALL advance data_out to the next word at that edge;
- data_out SHALL hold its last value while empty=1.
REQ-018 clr=1 at a rising edge SHALL:
- take priority over wr and rd;
- zero both pointers and count;
- set empty=1, almost_empty=1 and full=0, almost_full=0;
- clear overflow and underflow, with no pulse raised for requests ignored at that edge.
REQ-019 Memory contents SHALL NOT be reset or cleared; only control state is.

Reset
REQ-020 While reset=0, asynchronously:
- pointers and count SHALL be 0;
- empty=1, almost_empty=1;
- full=0, almost_full=0;
- overflow=0, underflow=0, data_out=0.
REQ-021 The first request honoured after reset SHALL be at the first rising edge with reset=1; asserting reset mid-operation SHALL discard all stored words immediately.

Verification
REQ-022 Defaults. Reset, write "a".."p" (16 words) -> almost_full rises when count=12, full=1 and count=16 after the 16th write; a 17th write -> overflow pulses for 1 cycle and count stays 16.
REQ-023 FWFT=0. After REQ-022, issue 16 reads -> data_out = "a".."p", each 1 cycle after its read; empty=1 after the 16th; a 17th read -> underflow pulses and data_out holds "p".
REQ-024 Full with rd=1, wr=1 at one edge, wr data "Q" -> count=16, "a" is popped, "Q" is readable as the 16th word; empty with rd=1, wr=1 -> count=1 and underflow pulses.
REQ-025 Wrap-around: write 10, read 8, write 12 -> count=14 and read order stays intact across pointer wrap; write 5 words, then drive reset low between edges -> empty=1 and count=0 immediately, and the next read underflows.
REQ-026 FWFT=1: write 0x48 into an empty FIFO -> next cycle empty=0 and data_out=0x48; rd=1 -> empty=1 the next cycle. clr=1 with 3 words stored and wr=1 -> count=0 and no overflow.
